// File: rtl/spi_pkg.sv
// ============================================================================
// spi_pkg : state encodings and constants shared by the SPI master and slave
// Rev 1.0
// ============================================================================
`default_nettype none

package spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ERR   = 2'd2
  } spi_state_e;

  // {CPOL, CPHA}
  localparam logic [1:0] SPI_MODE0         = 2'b00;
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hFF;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge.sv
// ============================================================================
// spi_sync_edge : multi-flop synchroniser with single-cycle rise/fall strobes
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
      hist_q <= RESET_VAL;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level_o = sync_q[SYNC_STAGES-1];
  assign rise_o  = level_o & ~hist_q;
  assign fall_o  = ~level_o & hist_q;

endmodule

`default_nettype wire

// File: rtl/spi_slave_rx.sv
// ============================================================================
// spi_slave_rx : oversampled SPI mode-0 slave, MSB-first, full-duplex reply
// Rev 1.0
// ============================================================================
`default_nettype none

module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int   DATA_W      = 8,
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              cs,
  input  logic              mosi,
  output logic              miso,
  input  logic [DATA_W-1:0] data_tx,
  input  logic              tx_load,
  output logic              tx_ready,
  output logic [DATA_W-1:0] data_rd,
  output logic              rd_valid,
  output logic              frame_err,
  output logic              busy,
  output logic [1:0]        state
);

  localparam int                 CNT_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0]  IDLE_WORD = (DATA_W == 8) ? DATA_W'(DEFAULT_IDLE_BYTE)
                                                           : {DATA_W{1'b1}};

  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_cs_lvl, w_cs_rise, w_cs_fall;
  logic w_mosi_lvl, w_mosi_rise, w_mosi_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .async_i(spi_clk),
    .level_o(w_sclk_lvl), .rise_o(w_sclk_rise), .fall_o(w_sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .async_i(cs),
    .level_o(w_cs_lvl), .rise_o(w_cs_rise), .fall_o(w_cs_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .async_i(mosi),
    .level_o(w_mosi_lvl), .rise_o(w_mosi_rise), .fall_o(w_mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{w_sclk_lvl, w_cs_lvl, w_mosi_rise, w_mosi_fall};

  spi_state_e        state_q;
  logic              miso_q;
  logic [DATA_W-1:0] data_rd_q;
  logic              rd_valid_q;
  logic              frame_err_q;
  logic              busy_q;
  logic              tx_ready_q;
  logic [DATA_W-1:0] tx_buf_q;
  logic [DATA_W-1:0] tx_shift_q;
  logic [DATA_W-1:0] rx_shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              skip_fall_q;

  logic              w_byte_done;
  logic              w_reload;
  logic              w_load_ok;
  logic [DATA_W-1:0] w_tx_next;
  logic [DATA_W-1:0] w_rx_next;

  // cs_rise beats a coincident sclk_rise, so a completed byte requires no cs_rise
  assign w_byte_done = (state_q == ST_SHIFT) && w_sclk_rise && !w_cs_rise &&
                       (bit_cnt_q == LAST_BIT);
  assign w_reload    = ((state_q == ST_IDLE) && w_cs_fall) || w_byte_done;
  assign w_tx_next   = tx_ready_q ? IDLE_WORD : tx_buf_q;
  // A load coinciding with a reload lands in the slot the reload just freed
  assign w_load_ok   = tx_load && (tx_ready_q || w_reload);
  assign w_rx_next   = {rx_shift_q[DATA_W-2:0], w_mosi_lvl};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      miso_q      <= IDLE_MISO;
      data_rd_q   <= '0;
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
      tx_ready_q  <= 1'b1;
      tx_buf_q    <= '0;
      tx_shift_q  <= '0;
      rx_shift_q  <= '0;
      bit_cnt_q   <= '0;
      skip_fall_q <= 1'b0;
    end else begin
      rd_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;

      if (w_load_ok) begin
        tx_buf_q   <= data_tx;
        tx_ready_q <= 1'b0;
      end else if (w_reload) begin
        tx_ready_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          miso_q <= IDLE_MISO;
          if (w_cs_fall) begin
            state_q     <= ST_SHIFT;
            busy_q      <= 1'b1;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            skip_fall_q <= 1'b0;
          end
        end

        ST_SHIFT: begin
          if (w_cs_rise) begin
            busy_q    <= 1'b0;
            miso_q    <= IDLE_MISO;
            bit_cnt_q <= '0;
            if (bit_cnt_q == '0) begin
              state_q <= ST_IDLE;
            end else begin
              state_q     <= ST_ERR;
              frame_err_q <= 1'b1;
            end
          end else if (w_sclk_rise) begin
            rx_shift_q <= w_rx_next;
            if (bit_cnt_q == LAST_BIT) begin
              bit_cnt_q   <= '0;
              data_rd_q   <= w_rx_next;
              rd_valid_q  <= 1'b1;
              skip_fall_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
          end else if (w_sclk_fall) begin
            // The reload already placed the next MSB on miso; do not shift it away
            if (skip_fall_q) begin
              skip_fall_q <= 1'b0;
            end else begin
              tx_shift_q <= {tx_shift_q[DATA_W-2:0], 1'b0};
              miso_q     <= tx_shift_q[DATA_W-2];
            end
          end
        end

        ST_ERR: begin
          state_q <= ST_IDLE;
          miso_q  <= IDLE_MISO;
        end

        default: begin
          state_q <= ST_IDLE;
          miso_q  <= IDLE_MISO;
        end
      endcase

      if (w_reload) begin
        tx_shift_q <= w_tx_next;
        miso_q     <= w_tx_next[DATA_W-1];
      end
    end
  end

  assign miso      = miso_q;
  assign tx_ready  = tx_ready_q;
  assign data_rd   = data_rd_q;
  assign rd_valid  = rd_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
// ============================================================================
// tb_spi_slave_rx : directed self-checking bench, master modelled at 8:1 clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       reset, spi_clk, cs, mosi, miso;
  logic       tx_load, tx_ready, rd_valid, frame_err, busy;
  logic [7:0] data_tx, data_rd;
  logic [1:0] state;

  int         checks = 0;
  int         errors = 0;
  int         rv_cnt = 0;
  int         fe_cnt = 0;
  int         busy_drop = 0;
  logic [7:0] rv_last = 8'h00;
  logic       frame_chk = 1'b0;

  always #5 clk = ~clk;

  spi_slave_rx #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_MISO(1'b1)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .cs(cs), .mosi(mosi), .miso(miso),
    .data_tx(data_tx), .tx_load(tx_load), .tx_ready(tx_ready), .data_rd(data_rd),
    .rd_valid(rd_valid), .frame_err(frame_err), .busy(busy), .state(state)
  );

  always @(posedge clk) begin
    #1;
    if (rd_valid === 1'b1) begin
      rv_cnt++;
      rv_last = data_rd;
    end
    if (frame_err === 1'b1) fe_cnt++;
    if (frame_chk && busy !== 1'b1) busy_drop++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One SPI bit: 4 clk low (data set up), master samples miso, 4 clk high
  task automatic spi_bit(input logic b, output logic m, output logic v);
    @(negedge clk); mosi = b;
    repeat (3) @(negedge clk);
    m = miso;
    spi_clk = 1'b1;
    v = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (rd_valid === 1'b1) v = 1'b1;
    end
    @(negedge clk); spi_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic lat);
    logic m, v;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], m, v);
      rx[i] = m;
    end
    lat = v;
  endtask

  task automatic cs_low();
    @(negedge clk); cs = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high(output logic saw_err);
    @(negedge clk); cs = 1'b1;
    saw_err = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (state === 2'd2) saw_err = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic load_tx(input logic [7:0] v);
    @(negedge clk); data_tx = v; tx_load = 1'b1;
    @(negedge clk); tx_load = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state); end
    checks++; if (miso !== 1'b1) begin errors++; $display("FAIL rst_miso got %b exp 1", miso); end
    checks++; if (data_rd !== 8'h00) begin errors++; $display("FAIL rst_data_rd got %h exp 00", data_rd); end
    checks++; if ({rd_valid, frame_err, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b exp 000", {rd_valid, frame_err, busy}); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_tx_ready got %b exp 1", tx_ready); end
    @(negedge clk); reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if ({state, miso, busy, tx_ready} !== 5'b00101) begin errors++; $display("FAIL post_rst got %b exp 00101", {state, miso, busy, tx_ready}); end
  endtask

  task automatic test_single_byte();
    int rv0, fe0; logic [7:0] rx; logic lat, saw;
    rv0 = rv_cnt; fe0 = fe_cnt; busy_drop = 0;
    cs_low(); frame_chk = 1'b1;
    spi_byte(8'hA5, rx, lat);
    frame_chk = 1'b0;
    cs_high(saw);
    checks++; if (rv_cnt - rv0 != 1) begin errors++; $display("FAIL single_rv_count got %0d exp 1", rv_cnt - rv0); end
    checks++; if (rv_last !== 8'hA5) begin errors++; $display("FAIL single_rv_data got %h exp a5", rv_last); end
    checks++; if (data_rd !== 8'hA5) begin errors++; $display("FAIL single_data_rd got %h exp a5", data_rd); end
    checks++; if (lat !== 1'b1) begin errors++; $display("FAIL single_latency got %b exp 1", lat); end
    checks++; if (busy_drop != 0) begin errors++; $display("FAIL single_busy got %0d drops exp 0", busy_drop); end
    checks++; if (fe_cnt != fe0 || saw !== 1'b0) begin errors++; $display("FAIL single_no_err got %0d/%b exp 0/0", fe_cnt - fe0, saw); end
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL single_miso got %h exp ff", rx); end
    checks++; if (busy !== 1'b0 || state !== 2'd0) begin errors++; $display("FAIL single_end got %b/%0d exp 0/0", busy, state); end
  endtask

  task automatic test_full_duplex();
    logic [7:0] rx; logic lat, saw;
    load_tx(8'h5A);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL fd_tx_ready_drop got %b exp 0", tx_ready); end
    cs_low();
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL fd_tx_ready_csfall got %b exp 1", tx_ready); end
    spi_byte(8'hFF, rx, lat);
    cs_high(saw);
    checks++; if (rx !== 8'h5A) begin errors++; $display("FAIL fd_miso got %h exp 5a", rx); end
    checks++; if (data_rd !== 8'hFF) begin errors++; $display("FAIL fd_data_rd got %h exp ff", data_rd); end
  endtask

  task automatic test_back_to_back();
    int rv0, fe0; logic [7:0] r1, r2; logic lat, saw;
    rv0 = rv_cnt; fe0 = fe_cnt;
    cs_low();
    spi_byte(8'h12, r1, lat);
    checks++; if (data_rd !== 8'h12 || rv_cnt - rv0 != 1) begin errors++; $display("FAIL b2b_first got %h/%0d exp 12/1", data_rd, rv_cnt - rv0); end
    spi_byte(8'h34, r2, lat);
    checks++; if (data_rd !== 8'h34 || rv_cnt - rv0 != 2) begin errors++; $display("FAIL b2b_second got %h/%0d exp 34/2", data_rd, rv_cnt - rv0); end
    checks++; if (r2 !== 8'hFF) begin errors++; $display("FAIL b2b_miso2 got %h exp ff", r2); end
    cs_high(saw);
    checks++; if (fe_cnt != fe0 || saw !== 1'b0) begin errors++; $display("FAIL b2b_no_err got %0d/%b exp 0/0", fe_cnt - fe0, saw); end
  endtask

  task automatic test_abort();
    int rv0, fe0; logic m, v, saw, lat; logic [7:0] rx;
    logic [7:0] pat;
    rv0 = rv_cnt; fe0 = fe_cnt; pat = 8'hF0;
    cs_low();
    for (int i = 7; i >= 3; i--) spi_bit(pat[i], m, v);
    cs_high(saw);
    checks++; if (fe_cnt - fe0 != 1) begin errors++; $display("FAIL abort_frame_err got %0d pulses exp 1", fe_cnt - fe0); end
    checks++; if (data_rd !== 8'h34 || rv_cnt != rv0) begin errors++; $display("FAIL abort_data_kept got %h/%0d exp 34/0", data_rd, rv_cnt - rv0); end
    checks++; if (saw !== 1'b1 || state !== 2'd0) begin errors++; $display("FAIL abort_err_idle got %b/%0d exp 1/0", saw, state); end
    cs_low();
    spi_byte(8'hC3, rx, lat);
    cs_high(saw);
    checks++; if (data_rd !== 8'hC3 || rv_cnt - rv0 != 1) begin errors++; $display("FAIL abort_recover got %h/%0d exp c3/1", data_rd, rv_cnt - rv0); end
  endtask

  task automatic test_tx_overload();
    logic [7:0] rx; logic lat, saw;
    load_tx(8'h11);
    load_tx(8'h22);
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL ovl_tx_ready got %b exp 0", tx_ready); end
    cs_low(); spi_byte(8'h00, rx, lat); cs_high(saw);
    checks++; if (rx !== 8'h11) begin errors++; $display("FAIL ovl_miso got %h exp 11", rx); end
    cs_low(); spi_byte(8'h81, rx, lat); cs_high(saw);
    checks++; if (rx !== 8'hFF || data_rd !== 8'h81) begin errors++; $display("FAIL ovl_dropped got %h/%h exp ff/81", rx, data_rd); end
  endtask

  task automatic test_reset_mid();
    int rv0; logic m, v, saw, lat; logic [7:0] rx;
    cs_low();
    load_tx(8'h77);
    for (int i = 0; i < 3; i++) spi_bit(1'b1, m, v);
    @(negedge clk); mosi = 1'b0;
    repeat (3) @(negedge clk); spi_clk = 1'b1;
    repeat (2) @(negedge clk); reset = 1'b1;
    #1;
    checks++; if ({state, miso, busy, rd_valid, frame_err} !== 6'b001000) begin errors++; $display("FAIL midrst_ctrl got %b exp 001000", {state, miso, busy, rd_valid, frame_err}); end
    checks++; if (data_rd !== 8'h00 || tx_ready !== 1'b1) begin errors++; $display("FAIL midrst_data got %h/%b exp 00/1", data_rd, tx_ready); end
    @(negedge clk); spi_clk = 1'b0; cs = 1'b1;
    repeat (4) @(negedge clk); reset = 1'b0;
    rv0 = rv_cnt;
    repeat (20) @(negedge clk);
    checks++; if (rv_cnt != rv0 || state !== 2'd0) begin errors++; $display("FAIL midrst_quiet got %0d/%0d exp 0/0", rv_cnt - rv0, state); end
    cs_low(); spi_byte(8'h3C, rx, lat); cs_high(saw);
    checks++; if (data_rd !== 8'h3C || rv_cnt - rv0 != 1) begin errors++; $display("FAIL midrst_next got %h/%0d exp 3c/1", data_rd, rv_cnt - rv0); end
    checks++; if (rx !== 8'hFF) begin errors++; $display("FAIL midrst_miso got %h exp ff", rx); end
  endtask

  initial begin
    reset = 1'b1; cs = 1'b1; spi_clk = 1'b0; mosi = 1'b0;
    tx_load = 1'b0; data_tx = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    test_single_byte();
    test_full_duplex();
    test_back_to_back();
    test_abort();
    test_tx_overload();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
